// File: rtl/logic_shift_sequencer.sv
// Command sequencer that iterates a one-bit-per-pass 24-bit logic unit to perform logic ops and multi-bit shifts/rotates.
// Optional LSEQ_CARRY_EN adds the res_c port: the last bit shifted out.
module logic_shift_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [4:0]  cmd_cnt,
   input  logic [23:0] cmd_a,
   input  logic [23:0] cmd_b,
   output logic [2:0]  lu_c,
   output logic [23:0] lu_in1,
   output logic [23:0] lu_in2,
   input  logic [23:0] lu_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [23:0] res_data,
   output logic        res_n,
`ifdef LSEQ_CARRY_EN
   output logic        res_z,
   output logic        res_c
`else
   output logic        res_z
`endif
);

   localparam int W = 24;

   // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // a result transfers on a rising edge where res_valid && res_ready. Neither
   // valid may depend on its ready, and a presented result never changes until taken.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [2:0]     op_r;
   logic [W-1:0]   b_r;
   logic [W-1:0]   acc;
   logic [4:0]     passes;
   logic [4:0]     pass_init;
   logic           accept;

   // Shifts take one pass per bit; logic ops always take exactly one pass.
   always_comb begin
      pass_init = 5'd1;
      if (cmd_op[2]) begin
         pass_init = (cmd_cnt > 5'd24) ? 5'd24 : cmd_cnt;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = (pass_init == 5'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (passes == 5'd1) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_r   <= 3'd0;
         b_r    <= '0;
         acc    <= '0;
         passes <= 5'd0;
      end else if (accept) begin
         op_r   <= cmd_op;
         b_r    <= cmd_b;
         acc    <= cmd_a;
         passes <= pass_init;
      end else if (state == RUN) begin
         acc    <= lu_out;
         passes <= passes - 5'd1;
      end
   end

`ifdef LSEQ_CARRY_EN
   logic carry;

   // Right shifts drop bit 0, left shifts drop bit 23; logic ops leave it at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         carry <= 1'b0;
      end else if (accept) begin
         carry <= 1'b0;
      end else if (state == RUN && op_r[2]) begin
         carry <= op_r[1] ? acc[W-1] : acc[0];
      end
   end

   assign res_c = carry;
`endif

   assign lu_c     = op_r;
   assign lu_in1   = acc;
   assign lu_in2   = b_r;
   assign res_data = acc;
   assign res_n    = acc[W-1];
   assign res_z    = (acc == '0);

endmodule

// File: tb/tb_logic_shift_sequencer.sv
// Self-checking bench for logic_shift_sequencer with a behavioural logic unit on the lu_* port.
module tb_logic_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_cnt;
  logic [23:0] cmd_a;
  logic [23:0] cmd_b;
  logic [2:0]  lu_c;
  logic [23:0] lu_in1;
  logic [23:0] lu_in2;
  logic [23:0] lu_out;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;
  logic        res_n;
  logic        res_z;
`ifdef LSEQ_CARRY_EN
  logic        res_c;
`endif

  logic [23:0] exp_q[$];
  logic        exp_c_q[$];
  int          exp_lat_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  logic_shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .lu_c      (lu_c),
    .lu_in1    (lu_in1),
    .lu_in2    (lu_in2),
    .lu_out    (lu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_n     (res_n),
`ifdef LSEQ_CARRY_EN
    .res_z     (res_z),
    .res_c     (res_c)
`else
    .res_z     (res_z)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- logic unit model ----------------
  function automatic logic [23:0] lu_model(input logic [2:0] c, input logic [23:0] x, input logic [23:0] y);
    case (c)
      3'b000:  return x ^ y;
      3'b001:  return x | y;
      3'b010:  return x & y;
      3'b011:  return ~x;
      3'b100:  return {1'b0, x[23:1]};
      3'b101:  return {x[0], x[23:1]};
      3'b110:  return {x[22:0], 1'b0};
      default: return {x[22:0], x[23]};
    endcase
  endfunction

  assign lu_out = lu_model(lu_c, lu_in1, lu_in2);

  // Expected result: apply the unit p times, remembering the bit that falls off each shift.
  function automatic void model(input logic [2:0] op, input logic [4:0] cnt, input logic [23:0] a,
                                input logic [23:0] b, output logic [23:0] r, output logic c, output int lat);
    int p;
    p = op[2] ? ((cnt > 5'd24) ? 24 : int'(cnt)) : 1;
    r = a;
    c = 1'b0;
    for (int i = 0; i < p; i++) begin
      if (op[2]) c = (op == 3'b100 || op == 3'b101) ? r[0] : r[23];
      r = lu_model(op, r, b);
    end
    lat = p + 1;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [2:0] op, input logic [4:0] cnt, input logic [23:0] a, input logic [23:0] b);
    logic [23:0] r;
    logic        c;
    int          lat;
    model(op, cnt, a, b, r, c, lat);
    exp_q.push_back(r);
    exp_c_q.push_back(c);
    exp_lat_q.push_back(lat);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [23:0] got);
    int          lat;
    logic [23:0] e;
    logic        ec;
    int          el;
    lat = 1;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
    end
    e  = exp_q.pop_front();
    ec = exp_c_q.pop_front();
    el = exp_lat_q.pop_front();
    check("latency", lat, el);
    check("res_data", res_data, e);
    check("res_n", res_n, e[23]);
    check("res_z", res_z, (e == 24'd0));
`ifdef LSEQ_CARRY_EN
    check("res_c", res_c, ec);
`endif
    got = res_data;
    if (res_ready) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] got;
    int          seen;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_cnt   = 5'd0;
    cmd_a     = 24'd0;
    cmd_b     = 24'd0;
    res_ready = 1'b1;
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 24'd0);
    check("rst_res_n", res_n, 1'b0);
    check("rst_res_z", res_z, 1'b1);
    check("rst_lu_c", lu_c, 3'd0);
    check("rst_lu_in1", lu_in1, 24'd0);
    check("rst_lu_in2", lu_in2, 24'd0);
`ifdef LSEQ_CARRY_EN
    check("rst_res_c", res_c, 1'b0);
`endif
    reset = 1'b0;
    tick();

    // directed cases
    issue_cmd(3'b010, 5'd0, 24'hF0F0F0, 24'h0FF00F);
    wait_result(got);
    check("and_value", got, 24'h00F000);

    issue_cmd(3'b100, 5'd4, 24'h80000F, 24'h000000);
    wait_result(got);
    check("lsr4_value", got, 24'h080000);

    issue_cmd(3'b111, 5'd24, 24'h123456, 24'h000000);
    wait_result(got);
    check("rol24_value", got, 24'h123456);

    issue_cmd(3'b111, 5'd31, 24'h123456, 24'h000000);
    wait_result(got);
    check("rol31_value", got, 24'h123456);

    issue_cmd(3'b110, 5'd0, 24'h000000, 24'h000000);
    wait_result(got);
    check("zero_cnt_value", got, 24'h000000);

    issue_cmd(3'b101, 5'd1, 24'h000001, 24'h000000);
    wait_result(got);
    check("ror1_value", got, 24'h800000);

    // backpressure: result held, commands ignored while DONE
    res_ready = 1'b0;
    issue_cmd(3'b001, 5'd0, 24'h0A0A0A, 24'h505050);
    wait_result(got);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'b011;
        cmd_a     = 24'hFFFFFF;
        cmd_b     = 24'h123123;
      end
      tick();
      cmd_valid = 1'b0;
      check("bp_res_data", res_data, 24'h5A5A5A);
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_res_valid", res_valid, 1'b1);
    end
    res_ready = 1'b1;
    tick();
    check("bp_release_ready", cmd_ready, 1'b1);
    check("bp_release_valid", res_valid, 1'b0);
    check("bp_not_captured", res_data, 24'h5A5A5A);
    check("bp_op_kept", lu_c, 3'b001);

    // random commands
    for (int i = 0; i < 20; i++) begin
      issue_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                24'($urandom), 24'($urandom));
      wait_result(got);
    end

    // reset on the third RUN cycle discards the command
    issue_cmd(3'b110, 5'd10, 24'h000ABC, 24'h000000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_c_q.delete();
    exp_lat_q.delete();
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_lu_in1", lu_in1, 24'd0);
    check("mid_rst_res_data", res_data, 24'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) seen++;
      tick();
    end
    check("mid_rst_no_result", seen, 0);

    // sequencer still works after the abort
    issue_cmd(3'b000, 5'd7, 24'hABCDEF, 24'hFFFFFF);
    wait_result(got);
    check("post_rst_xor", got, 24'h543210);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
